wb_sdram_arbiter: RTL and testbench
===================================

// Module: wb_sdram_arbiter
// PURPOSE
//   Two-master Wishbone arbiter that shares the single Wishbone slave port of the
//   SDRAM controller (26-bit address, dw-bit data, byte selects, CTI bursts).
//   Round-robin arbitration. A grant is held for the whole master cycle (cyc high),
//   so CTI bursts are never split. A per-access watchdog returns err to the master
//   and releases the bus if the SDRAM side never acks.
// PARAMETERS
//   dw       32   data width; sel width is dw/8
//   AW       26   address width
//   TIMEOUT  64   stb-without-ack cycles before abort; 0 disables the watchdog
// PORTS
//   sys_clk            in   1      system clock; all state changes on the rising edge
//   RESET              in   1      asynchronous, active-high reset
//   mN_cyc_i           in   1      master N (N=0,1) cycle request
//   mN_stb_i           in   1      master N strobe
//   mN_we_i            in   1      master N write enable (1=write, 0=read)
//   mN_addr_i          in   AW     master N address
//   mN_dat_i           in   dw     master N write data
//   mN_sel_i           in   dw/8   master N byte enables
//   mN_cti_i           in   3      master N cycle type identifier
//   mN_dat_o           out  dw     read data to master N (s_dat_i broadcast)
//   mN_ack_o           out  1      ack to master N
//   mN_err_o           out  1      watchdog abort to master N, 1-cycle pulse
//   s_cyc_o/s_stb_o/s_we_o  out  1  to SDRAM controller wb_cyc_i/wb_stb_i/wb_we_i
//   s_addr_o           out  AW     to wb_addr_i
//   s_dat_o            out  dw     to wb_dat_i
//   s_sel_o            out  dw/8   to wb_sel_i
//   s_cti_o            out  3      to wb_cti_i
//   s_dat_i            in   dw     from wb_dat_o
//   s_ack_i            in   1      from wb_ack_o
//   gnt_o              out  2      one-hot current owner; 2'b00 when idle
// BEHAVIOUR
//   Reset:
//     - state=IDLE, last_gnt=1 (m0 wins first tie), watchdog count=0.
//     - gnt_o=0, all s_* outputs 0, all mN_ack_o/mN_err_o 0.
//   FSM states: IDLE, GNT0, GNT1. State register is clocked; the output mux is
//   combinational from state.
//   IDLE transitions:
//     - m0_cyc_i only -> GNT0.
//     - m1_cyc_i only -> GNT1.
//     - Both requesting -> the master other than last_gnt.
//   GNTn transitions:
//     - Stay while mn_cyc_i=1.
//     - mn_cyc_i=0 -> IDLE; last_gnt<=n.
//     - Every handover passes through one IDLE cycle; there are no back-to-back grants.
//   Latency: cyc sampled high at edge k gives s_cyc_o/s_stb_o high from cycle k+1.
//   Mux in GNTn:
//     - s_* outputs = master n inputs.
//     - mn_ack_o = s_ack_i; the other master's ack = 0.
//   In IDLE:
//     - s_cyc_o = s_stb_o = 0.
//     - A stray s_ack_i is dropped; it goes to no master.
//   mN_dat_o = s_dat_i to both masters; only the acked master may sample it.
//   Watchdog (TIMEOUT>0):
//     - Counter width $clog2(TIMEOUT+1).
//     - Increments each cycle with s_stb_o=1 and s_ack_i=0.
//     - Clears on s_ack_i, on any state change, and when s_stb_o=0.
//     - On reaching TIMEOUT: mn_err_o pulses 1 cycle, the ack is suppressed,
//       state -> IDLE, last_gnt<=n.
//     - The aborted master must drop cyc. If its cyc is still high, it re-arbitrates
//       as a new request.
//   Simultaneous s_ack_i and timeout in the same cycle: the ack wins, no err, counter clears.
//   Reset asserted mid-cycle: immediate return to the reset values. The master and
//   the SDRAM controller are reset on the same RESET.
//   No combinational path from mN_cyc_i to gnt_o.
// TESTING
//   1. m0 single write, addr=26'h0000100, dat=32'hA5A5_5A5A, sel=4'hF
//      -> s_cyc_o high 1 cycle after m0_cyc_i; m0_ack_o mirrors s_ack_i; m1_ack_o=0.
//   2. m0 and m1 assert cyc on the same edge after reset
//      -> GNT0 first; after m0 drops cyc: 1 IDLE cycle, then GNT1.
//   3. m0 4-beat burst (cti=3'b010 x3, then 3'b111) with m1_cyc_i held high
//      -> all 4 beats go to m0 uninterrupted; m1 granted only after m0_cyc_i falls.
//   4. TIMEOUT=16, SDRAM model never acks m1 read
//      -> m1_err_o pulses on the 16th stb cycle; gnt_o returns to 2'b00; m1_ack_o stays 0.
//   5. Both masters issue continuous back-to-back single accesses for 20 cycles
//      -> grants alternate m0,m1,m0,...; no master is granted twice in a row.
//   6. RESET asserted during a GNT1 burst beat
//      -> all outputs 0 asynchronously; after release, m0 wins the next tie.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: round-robin two-master Wishbone arbiter for the SDRAM slave port, with per-access watchdog
module wb_sdram_arbiter #(
  parameter int dw      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 64
) (
  input  logic            sys_clk,
  input  logic            RESET,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [dw-1:0]   m0_dat_i,
  input  logic [dw/8-1:0] m0_sel_i,
  input  logic [2:0]      m0_cti_i,
  output logic [dw-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [dw-1:0]   m1_dat_i,
  input  logic [dw/8-1:0] m1_sel_i,
  input  logic [2:0]      m1_cti_i,
  output logic [dw-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [dw-1:0]   s_dat_o,
  output logic [dw/8-1:0] s_sel_o,
  output logic [2:0]      s_cti_o,
  input  logic [dw-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, next_state;
  logic last_gnt;
  logic [CW-1:0] cnt;
  logic g0, g1, timeout;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt_o = {g1, g0};
  assign s_cyc_o  = g0 ? m0_cyc_i  : g1 ? m1_cyc_i  : 1'b0;
  assign s_stb_o  = g0 ? m0_stb_i  : g1 ? m1_stb_i  : 1'b0;
  assign s_we_o   = g0 ? m0_we_i   : g1 ? m1_we_i   : 1'b0;
  assign s_addr_o = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i  : g1 ? m1_dat_i  : '0;
  assign s_sel_o  = g0 ? m0_sel_i  : g1 ? m1_sel_i  : '0;
  assign s_cti_o  = g0 ? m0_cti_i  : g1 ? m1_cti_i  : 3'b000;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // an ack in the final watchdog cycle wins, so timeout already excludes it
  assign timeout  = (TIMEOUT != 0) && s_stb_o && !s_ack_i && cnt == CW'(TIMEOUT - 1);
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & timeout;
  assign m1_err_o = g1 & timeout;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = (m0_cyc_i && (!m1_cyc_i || last_gnt)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
      GNT0:    next_state = (!m0_cyc_i || timeout) ? IDLE : GNT0;
      GNT1:    next_state = (!m1_cyc_i || timeout) ? IDLE : GNT1;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= '0;
    end else begin
      state <= next_state;
      if (state != IDLE && next_state == IDLE) last_gnt <= g1;
      cnt <= (TIMEOUT == 0 || next_state != state || !s_stb_o || s_ack_i) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: vector table, directed corner cases and a randomized reference-model run
module tb_wb_sdram_arbiter;
  localparam int TMO = 16;
  logic clk, rst;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [25:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [1:0] gnt_o;
  int total, bad;

  wb_sdram_arbiter #(.dw(32), .AW(26), .TIMEOUT(TMO)) dut (
    .sys_clk(clk), .RESET(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = '0;
    {m0_addr_i, m1_addr_i, m0_dat_i, m1_dat_i, s_dat_i} = '0;
    {m0_sel_i, m1_sel_i, m0_cti_i, m1_cti_i} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic c0, c1, a;
    logic [1:0] gnt;
    logic ack0, ack1, scyc;
  } vec_t;
  vec_t tbl[11];

  int owner, last, waitc;
  logic [67:0] exp_s;
  logic [1:0] exp_g, last_grant, prev_g, g;
  logic to, drop0, drop1;
  int ngr;

  initial begin
    total = 0;
    bad = 0;
    clear_inputs();
    rst = 1'b1;
    s_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_s", {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o}, 68'h0);
    chk("reset_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    step();
    rst = 1'b0;
    s_ack_i = 1'b0;

    // both request together after reset: m0 first, one IDLE cycle, then m1; stray ack in IDLE dropped
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step();
      m0_cyc_i = tbl[i].c0;
      m0_stb_i = tbl[i].c0;
      m1_cyc_i = tbl[i].c1;
      m1_stb_i = tbl[i].c1;
      s_ack_i  = tbl[i].a;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), gnt_o, tbl[i].gnt);
      chk($sformatf("vec%0d_acks", i), {m0_ack_o, m1_ack_o}, {tbl[i].ack0, tbl[i].ack1});
      chk($sformatf("vec%0d_scyc", i), s_cyc_o, tbl[i].scyc);
    end
    clear_inputs();

    // m0 single write
    step();
    m0_cyc_i = 1'b1;
    m0_stb_i = 1'b1;
    m0_we_i = 1'b1;
    m0_addr_i = 26'h0000100;
    m0_dat_i = 32'hA5A5_5A5A;
    m0_sel_i = 4'hF;
    @(negedge clk);
    chk("t1_scyc_latency", s_cyc_o, 1'b0);
    step();
    s_ack_i = 1'b1;
    @(negedge clk);
    chk("t1_scyc_stb", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    chk("t1_addr", s_addr_o, 26'h0000100);
    chk("t1_dat", s_dat_o, 32'hA5A5_5A5A);
    chk("t1_sel", s_sel_o, 4'hF);
    chk("t1_acks", {m0_ack_o, m1_ack_o}, 2'b10);
    step();
    clear_inputs();
    step();

    // m0 4-beat burst while m1 keeps requesting
    m0_cyc_i = 1'b1;
    m0_stb_i = 1'b1;
    m0_cti_i = 3'b010;
    for (int b = 0; b < 4; b++) begin
      step();
      m1_cyc_i = 1'b1;
      m1_stb_i = 1'b1;
      s_ack_i = 1'b1;
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      @(negedge clk);
      chk($sformatf("t3_beat%0d_gnt", b), gnt_o, 2'b01);
      chk($sformatf("t3_beat%0d_acks", b), {m0_ack_o, m1_ack_o}, 2'b10);
      chk($sformatf("t3_beat%0d_cti", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
    end
    step();
    m0_cyc_i = 1'b0;
    m0_stb_i = 1'b0;
    s_ack_i = 1'b0;
    @(negedge clk);
    chk("t3_hold_after_drop", gnt_o, 2'b01);
    step();
    @(negedge clk);
    chk("t3_idle_gap", gnt_o, 2'b00);
    step();
    @(negedge clk);
    chk("t3_m1_granted", gnt_o, 2'b10);
    step();
    clear_inputs();
    step();

    // m1 read never acked: watchdog fires on the 16th strobe cycle
    m1_cyc_i = 1'b1;
    m1_stb_i = 1'b1;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t4_err_k%0d", k), m1_err_o, k == TMO);
      chk($sformatf("t4_ack_k%0d", k), {m1_ack_o, gnt_o}, 3'b010);
    end
    step();
    m1_cyc_i = 1'b0;
    m1_stb_i = 1'b0;
    @(negedge clk);
    chk("t4_released", {gnt_o, m1_err_o, m0_err_o}, 4'b0000);
    step();

    // continuous contention: grants must alternate
    s_ack_i = 1'b1;
    drop0 = 1'b0;
    drop1 = 1'b0;
    last_grant = 2'b10;
    prev_g = 2'b00;
    ngr = 0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) step();
      m0_cyc_i = !drop0;
      m0_stb_i = !drop0;
      m1_cyc_i = !drop1;
      m1_stb_i = !drop1;
      drop0 = 1'b0;
      drop1 = 1'b0;
      @(negedge clk);
      g = gnt_o;
      if (g != 2'b00 && prev_g == 2'b00) begin
        chk($sformatf("t5_alternate%0d", ngr), g, {last_grant[0], last_grant[1]});
        last_grant = g;
        ngr++;
      end else if (g != 2'b00) chk($sformatf("t5_no_handover_c%0d", c), g, prev_g);
      if (g == 2'b01) drop0 = 1'b1;
      if (g == 2'b10) drop1 = 1'b1;
      prev_g = g;
    end
    chk("t5_grant_count", ngr >= 5, 1'b1);
    step();
    clear_inputs();
    repeat (2) step();

    // async reset during a GNT1 burst beat
    m1_cyc_i = 1'b1;
    m1_stb_i = 1'b1;
    m1_cti_i = 3'b010;
    step();
    @(negedge clk);
    chk("t6_gnt1", gnt_o, 2'b10);
    @(posedge clk);
    #2;
    s_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_async_gnt", gnt_o, 2'b00);
    chk("t6_async_s", {s_cyc_o, s_stb_o, s_cti_o}, 5'b00000);
    chk("t6_async_ack", {m0_ack_o, m1_ack_o}, 2'b00);
    step();
    rst = 1'b0;
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b1;
    m0_stb_i = 1'b1;
    step();
    @(negedge clk);
    chk("t6_m0_wins_tie", gnt_o, 2'b01);
    clear_inputs();

    // randomized run against a cycle-level reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    owner = -1;
    last = 1;
    waitc = 0;
    for (int i = 0; i < 700; i++) begin
      step();
      m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom);
      m1_we_i = 1'($urandom);
      m0_addr_i = 26'($urandom);
      m1_addr_i = 26'($urandom);
      m0_dat_i = $urandom;
      m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom);
      m1_sel_i = 4'($urandom);
      m0_cti_i = 3'($urandom);
      m1_cti_i = 3'($urandom);
      s_dat_i = $urandom;
      s_ack_i = (i < 350) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
      @(negedge clk);
      exp_g = (owner < 0) ? 2'b00 : 2'(1 << owner);
      exp_s = (owner == 0) ? {m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i, m0_cti_i} :
              (owner == 1) ? {m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i, m1_cti_i} : 68'h0;
      to = owner >= 0 && exp_s[66] && !s_ack_i && waitc == TMO - 1;
      chk($sformatf("rnd%0d_gnt", i), gnt_o, exp_g);
      chk($sformatf("rnd%0d_s", i), {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o}, exp_s);
      chk($sformatf("rnd%0d_ack_err", i), {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o},
          {owner == 0 && s_ack_i, owner == 1 && s_ack_i, owner == 0 && to, owner == 1 && to});
      chk($sformatf("rnd%0d_dat", i), {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
      if (owner < 0) begin
        if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
        else if (m0_cyc_i) owner = 0;
        else if (m1_cyc_i) owner = 1;
        waitc = 0;
      end else if (!(owner == 0 ? m0_cyc_i : m1_cyc_i) || to) begin
        last = owner;
        owner = -1;
        waitc = 0;
      end else waitc = (exp_s[66] && !s_ack_i) ? waitc + 1 : 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
